stack_node_param: RTL and testbench

Parametrised stack/queue storage node for the TIS-style grid. It buffers up to DEPTH signed words received from any of NPORTS neighbour channels and offers the head word back to the neighbours, one channel at a time. Compared with the fixed 4-port, 15-deep LIFO node it adds:
- runtime LIFO/FIFO mode;
- round-robin (fair) input arbitration;
- occupancy status outputs.

---
 rtl/stack_node_param.sv | 189 ++++++++++++++++++
 tb/tb_stack_node_param.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_node_param.sv
// stack_node_param: grid storage node. It buffers up to DEPTH words in
// LIFO or FIFO order, with round-robin push arbitration and a rotating
// output offer.
//
// Ports:
//   clk, rst      rising-edge clock; async active-high reset
//   mode          0=LIFO, 1=FIFO; latched only while empty
//   rready/din    per-channel input request and packed input words
//   wready        per-channel consumer accept of the offered word
//   read          registered one-cycle capture acknowledge
//   write         registered one-hot output offer
//   out           registered head word
//   depth/full/empty  registered occupancy status
module stack_node_param #(
    parameter int WIDTH  = 11,
    parameter int DEPTH  = 15,
    parameter int NPORTS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mode,
    input  logic [NPORTS-1:0]          rready,
    input  logic [NPORTS*WIDTH-1:0]    din,
    input  logic [NPORTS-1:0]          wready,
    output logic [NPORTS-1:0]          read,
    output logic [NPORTS-1:0]          write,
    output logic signed [WIDTH-1:0]    out,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int QW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef logic [WIDTH-1:0] word_t;

    word_t             mem_q [DEPTH];
    logic [PW-1:0]     base_q, base_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              fifo_q;
    logic [QW-1:0]     rr_q, rr_d;
    logic [QW-1:0]     offp_q, offp_d;
    logic [NPORTS-1:0] read_q, read_d;
    logic [NPORTS-1:0] write_q, write_d;
    word_t             out_q, out_d;
    logic              full_q, empty_q;

    word_t             din_a [NPORTS];
    logic              gnt_ok;
    logic [QW-1:0]     gnt_idx;
    logic              push, pop;
    word_t             push_w;
    logic [PW-1:0]     wr_idx;
    logic [PW-1:0]     tail_idx, top_idx, below_idx, next_idx;

    // Storage is a ring: base_q is the FIFO head or the LIFO bottom,
    // and entries occupy base_q .. base_q+cnt_q-1 modulo DEPTH.
    function automatic logic [PW-1:0] slot(input logic [PW-1:0] b,
                                           input int off);
        int s;
        s = int'(b) + off;
        if (s >= DEPTH) s = s - DEPTH;
        else if (s < 0) s = s + DEPTH;
        return PW'(s);
    endfunction

    function automatic logic [QW-1:0] pwrap(input int v);
        return QW'((v >= NPORTS) ? v - NPORTS : v);
    endfunction

    always_comb begin
        for (int j = 0; j < NPORTS; j++) begin
            din_a[j] = din[j*WIDTH +: WIDTH];
        end
    end

    // Round-robin search from rr_q; a channel whose read is high is
    // skipped so a source that is still dropping rready is not
    // captured twice.
    always_comb begin
        gnt_ok  = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (!gnt_ok
                && rready[pwrap(int'(rr_q) + k)]
                && !read_q[pwrap(int'(rr_q) + k)]) begin
                gnt_ok  = 1'b1;
                gnt_idx = pwrap(int'(rr_q) + k);
            end
        end
    end

    // A full node refuses pushes even when a pop happens this cycle.
    assign push   = gnt_ok & ~full_q;
    assign pop    = |(write_q & wready);
    assign push_w = din_a[gnt_idx];

    assign tail_idx  = slot(base_q, int'(cnt_q));
    assign top_idx   = slot(base_q, int'(cnt_q) - 1);
    assign below_idx = slot(base_q, int'(cnt_q) - 2);
    assign next_idx  = slot(base_q, 1);

    always_comb begin
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        base_d = base_q;
        wr_idx = tail_idx;
        out_d  = out_q;
        rr_d   = rr_q;
        read_d = '0;
        if (push) begin
            rr_d   = pwrap(int'(gnt_idx) + 1);
            read_d = NPORTS'(1) << gnt_idx;
        end
        if (fifo_q) begin
            if (pop) base_d = next_idx;
            if (pop) begin
                if (cnt_q == CNT_ONE) begin
                    if (push) out_d = push_w;
                end else begin
                    out_d = mem_q[next_idx];
                end
            end else if (push && cnt_q == '0) begin
                out_d = push_w;
            end
        end else begin
            // LIFO push+pop overwrites the popped top slot.
            if (pop) wr_idx = top_idx;
            if (push) out_d = push_w;
            else if (pop && cnt_q > CNT_ONE) out_d = mem_q[below_idx];
        end
    end

    // Offer: rotate while unaccepted; after a transfer write drops for
    // one cycle and the next offer goes to the following channel.
    always_comb begin
        write_d = '0;
        offp_d  = offp_q;
        if (pop) begin
            offp_d = pwrap(int'(offp_q) + 1);
        end else if (|write_q) begin
            offp_d  = pwrap(int'(offp_q) + 1);
            write_d = NPORTS'(1) << pwrap(int'(offp_q) + 1);
        end else if (cnt_q != '0) begin
            write_d = NPORTS'(1) << offp_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_idx] <= push_w;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q  <= '0;
            cnt_q   <= '0;
            fifo_q  <= 1'b0;
            rr_q    <= '0;
            offp_q  <= '0;
            read_q  <= '0;
            write_q <= '0;
            out_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            if (cnt_q == '0) fifo_q <= mode;
            rr_q    <= rr_d;
            offp_q  <= offp_d;
            read_q  <= read_d;
            write_q <= write_d;
            out_q   <= out_d;
            full_q  <= (cnt_d == CNT_MAX);
            empty_q <= (cnt_d == '0);
        end
    end

    assign read  = read_q;
    assign write = write_q;
    assign out   = out_q;
    assign depth = cnt_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: tb/tb_stack_node_param.sv
// tb_stack_node_param: directed scenario bench for stack_node_param
// (DEPTH=4, NPORTS=4, WIDTH=11).
module tb_stack_node_param;

    localparam int W  = 11;
    localparam int D  = 4;
    localparam int N  = 4;
    localparam int CW = $clog2(D + 1);

    logic                clk = 1'b0;
    logic                rst;
    logic                mode;
    logic [N-1:0]        rready;
    logic [N*W-1:0]      din;
    logic [N-1:0]        wready;
    logic [N-1:0]        read;
    logic [N-1:0]        write;
    logic signed [W-1:0] out;
    logic [CW-1:0]       depth;
    logic                full;
    logic                empty;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    stack_node_param #(.WIDTH(W), .DEPTH(D), .NPORTS(N)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .rready(rready), .din(din), .wready(wready),
        .read(read), .write(write), .out(out),
        .depth(depth), .full(full), .empty(empty)
    );

    task automatic do_reset();
        rst = 1'b1;
        rready = '0;
        wready = '0;
        din = '0;
        mode = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_word(input int ch, input logic [W-1:0] v,
                             output bit ok);
        ok = 1'b0;
        din[ch*W +: W] = v;
        rready[ch] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (read[ch]) begin
                ok = 1'b1;
                break;
            end
        end
        rready[ch] = 1'b0;
    endtask

    task automatic pop_any(output logic [W-1:0] v, output bit ok);
        ok = 1'b0;
        v = '0;
        for (int i = 0; i < 20; i++) begin
            if (write != '0) begin
                wready = write;
                v = out;
                @(negedge clk);
                wready = '0;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rready = '0;
        wready = '0;
        din = '0;
        mode = 1'b0;
        #1;
        tests++;
        if ({out, write, read, depth, full, empty} !==
            {11'd0, 4'b0, 4'b0, 3'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_values got %h want %h",
                     {out, write, read, depth, full, empty},
                     {11'd0, 4'b0, 4'b0, 3'd0, 1'b0, 1'b1});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lifo();
        bit ok;
        int n;
        logic [W-1:0] v;
        logic [W-1:0] exp_v [3];
        logic [W-1:0] in_v [3];
        exp_v = '{11'd7, 11'd6, 11'd5};
        in_v  = '{11'd5, 11'd6, 11'd7};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            push_word(0, in_v[k], ok);
            tests++;
            if (!ok || read !== 4'b0001) begin
                fails++;
                $display("FAIL lifo_read%0d got %b want 0001", k, read);
            end
        end
        tests++;
        if (depth !== 3'd3 || out !== 11'sd7) begin
            fails++;
            $display("FAIL lifo_fill got depth=%0d out=%0d want 3/7",
                     depth, out);
        end
        wready = 4'b0010;
        n = 0;
        for (int i = 0; i < 60 && n < 3; i++) begin
            if (write[1]) begin
                v = out;
                @(negedge clk);
                tests++;
                if (v !== exp_v[n] || write !== 4'b0) begin
                    fails++;
                    $display("FAIL lifo_pop%0d got %0d/%b want %0d/0000",
                             n, v, write, exp_v[n]);
                end
                n++;
            end else begin
                @(negedge clk);
            end
        end
        tests++;
        if (n != 3) begin
            fails++;
            $display("FAIL lifo_pop_count got %0d want 3", n);
        end
        @(negedge clk);
        wready = '0;
        tests++;
        if (empty !== 1'b1 || write !== 4'b0 || depth !== 3'd0) begin
            fails++;
            $display("FAIL lifo_empty got e=%b w=%b d=%0d want 1/0000/0",
                     empty, write, depth);
        end
    endtask

    task automatic test_fifo();
        bit ok;
        logic [W-1:0] v;
        logic [W-1:0] in_v [3];
        in_v = '{11'd5, 11'd6, 11'd7};
        do_reset();
        mode = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            push_word(0, in_v[k], ok);
            tests++;
            if (!ok || out !== 11'sd5) begin
                fails++;
                $display("FAIL fifo_push%0d got ok=%0b out=%0d want 1/5",
                         k, ok, out);
            end
        end
        mode = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pop_any(v, ok);
            tests++;
            if (!ok || v !== in_v[k] || write !== 4'b0) begin
                fails++;
                $display("FAIL fifo_pop%0d got %0d/%b want %0d/0000",
                         k, v, write, in_v[k]);
            end
        end
        tests++;
        if (empty !== 1'b1) begin
            fails++;
            $display("FAIL fifo_empty got %b want 1", empty);
        end
        @(negedge clk);
        push_word(0, 11'd1, ok);
        push_word(0, 11'd2, ok);
        tests++;
        if (out !== 11'sd2 || depth !== 3'd2) begin
            fails++;
            $display("FAIL fifo_relatch got out=%0d d=%0d want 2/2",
                     out, depth);
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_r [4];
        logic [W-1:0] vals [4];
        exp_r = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        vals  = '{11'h7FF, 11'd2, 11'd3, 11'h400};
        do_reset();
        for (int j = 0; j < 4; j++) din[j*W +: W] = vals[j];
        rready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++;
            if (read !== exp_r[k] || out !== vals[k]) begin
                fails++;
                $display("FAIL fair_grant%0d got %b/%h want %b/%h",
                         k, read, out, exp_r[k], vals[k]);
            end
        end
        @(negedge clk);
        tests++;
        if (read !== 4'b0 || full !== 1'b1 || depth !== 3'd4) begin
            fails++;
            $display("FAIL fair_full got r=%b f=%b d=%0d want 0000/1/4",
                     read, full, depth);
        end
        rready = '0;
    endtask

    task automatic test_full();
        bit ok;
        bit seen;
        logic [W-1:0] v;
        do_reset();
        for (int k = 1; k <= 4; k++) push_word(0, W'(k), ok);
        tests++;
        if (full !== 1'b1 || depth !== 3'd4 || empty !== 1'b0) begin
            fails++;
            $display("FAIL full_set got f=%b d=%0d want 1/4", full, depth);
        end
        din[1*W +: W] = 11'd5;
        rready[1] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (read != '0) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL full_refuse got read while full want none");
        end
        pop_any(v, ok);
        tests++;
        if (!ok || v !== 11'd4 || depth !== 3'd3 || read !== 4'b0) begin
            fails++;
            $display("FAIL full_pop got %0d d=%0d r=%b want 4/3/0000",
                     v, depth, read);
        end
        @(negedge clk);
        rready = '0;
        tests++;
        if (read !== 4'b0010 || out !== 11'sd5 || full !== 1'b1) begin
            fails++;
            $display("FAIL full_accept got r=%b out=%0d f=%b want 0010/5/1",
                     read, out, full);
        end
    endtask

    task automatic test_simul();
        bit ok;
        bit seen;
        logic [W-1:0] v;
        do_reset();
        push_word(0, 11'd3, ok);
        push_word(0, 11'd9, ok);
        @(negedge clk);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (write != '0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests++;
        if (!seen || out !== 11'sd9 || depth !== 3'd2) begin
            fails++;
            $display("FAIL simul_pre got out=%0d d=%0d want 9/2",
                     out, depth);
        end
        wready = write;
        din[0 +: W] = 11'd11;
        rready[0] = 1'b1;
        @(negedge clk);
        wready = '0;
        rready = '0;
        tests++;
        if (depth !== 3'd2 || out !== 11'sd11 || read !== 4'b0001
            || write !== 4'b0) begin
            fails++;
            $display("FAIL simul_post got d=%0d out=%0d r=%b w=%b want 2/11/0001/0000",
                     depth, out, read, write);
        end
        pop_any(v, ok);
        tests++;
        if (!ok || v !== 11'd11 || out !== 11'sd3) begin
            fails++;
            $display("FAIL simul_drain got %0d/%0d want 11/3", v, out);
        end
    endtask

    task automatic test_rotation_reset();
        bit ok;
        logic [N-1:0] exp_w [5];
        exp_w = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        push_word(0, 11'd7, ok);
        tests++;
        if (!ok || write !== 4'b0 || depth !== 3'd1) begin
            fails++;
            $display("FAIL rot_push got w=%b d=%0d want 0000/1", write, depth);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++;
            if (write !== exp_w[k]) begin
                fails++;
                $display("FAIL rot_offer%0d got %b want %b",
                         k, write, exp_w[k]);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({out, write, read, depth, full, empty} !==
            {11'd0, 4'b0, 4'b0, 3'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL rot_async_reset got %h want %h",
                     {out, write, read, depth, full, empty},
                     {11'd0, 4'b0, 4'b0, 3'd0, 1'b0, 1'b1});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lifo();
        test_fifo();
        test_fairness();
        test_full();
        test_simul();
        test_rotation_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
